// File: rtl/spi_master_if.sv
// spi_master_if -- register-side handshake bundle for spi_master.
//   master modport (the SPI block): consumes start/tx_data/mode/cs_sel,
//     produces ready/done/rx_data.
//   slave modport (the bus front end): the mirror image.
// Optional macro SPI_MASTER_LOOPBACK_EN adds the per-transfer loopback bit.
interface spi_master_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 1
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        mode;     // {CPOL,CPHA}
  logic [CS_W-1:0]   cs_sel;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic              loopback;
`endif
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  modport master (
`ifdef SPI_MASTER_LOOPBACK_EN
    input  loopback,
`endif
    input  start, tx_data, mode, cs_sel,
    output ready, done, rx_data
  );

  modport slave (
`ifdef SPI_MASTER_LOOPBACK_EN
    output loopback,
`endif
    output start, tx_data, mode, cs_sel,
    input  ready, done, rx_data
  );
endinterface

// File: rtl/spi_master.sv
// spi_master -- parametrised SPI master, MSB first, all four SPI modes.
//   clk, reset   : system clock, synchronous active-high reset
//   bus          : spi_master_if.master (start/tx_data/mode/cs_sel in,
//                  ready/done/rx_data out)
//   sclk, mosi   : SPI clock / data out (registered)
//   miso         : SPI data in, sampled without a synchroniser
//   cs_n         : NUM_CS active-low chip selects
// Optional macro SPI_MASTER_LOOPBACK_EN: when the latched loopback bit is
// set, the internal mosi is sampled instead of miso.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_if.master      bus,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int CNT_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
  state_t state, state_n;

  logic [CNT_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;   // number of SCLK edges already produced
  logic [EDGE_W-1:0] edge_num;   // number of the edge a tick would produce
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [NUM_CS-1:0] cs_dec;
  logic              cpha_q;
  logic              tick, sclk_edge, leading, last_edge;
  logic              sample_edge, drive_edge, sample_bit;

  assign tick      = (div_cnt == CNT_W'(CLK_DIV - 1));
  assign sclk_edge = tick && (state == LEAD || state == SHIFT);
  assign edge_num  = edge_cnt + 1'b1;
  assign leading   = edge_num[0];
  assign last_edge = (edge_num == EDGE_W'(2 * DATA_W));
  // CPHA=0 samples on leading edges and drives on trailing ones; CPHA=1 swaps.
  // The trailing edge that ends the word drives nothing for CPHA=0.
  assign sample_edge = sclk_edge && (leading ^ cpha_q);
  assign drive_edge  = sclk_edge && !(leading ^ cpha_q) && !(!cpha_q && last_edge);
  assign bus.ready   = (state == IDLE);

`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  assign sample_bit = lb_q ? mosi : miso;
`else
  assign sample_bit = miso;
`endif

  // Out-of-range cs_sel matches no line, leaving every select high.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (bus.cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (bus.start)        state_n = LEAD;
      LEAD:  if (tick)             state_n = SHIFT;
      SHIFT: if (tick && last_edge) state_n = TRAIL;
      TRAIL: if (tick)             state_n = IDLE;
      default:                     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      edge_cnt    <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      cpha_q      <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= '1;
      bus.done    <= 1'b0;
      bus.rx_data <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
      lb_q        <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        sclk     <= bus.mode[1];
        div_cnt  <= '0;
        edge_cnt <= '0;
        if (bus.start) begin
          cpha_q <= bus.mode[0];
          cs_n   <= cs_dec;
          rx_sh  <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
          lb_q   <= bus.loopback;
`endif
          // CPHA=0 presents the MSB before the first edge; CPHA=1 waits for edge 1.
          if (!bus.mode[0]) begin
            mosi  <= bus.tx_data[DATA_W-1];
            tx_sh <= {bus.tx_data[DATA_W-2:0], 1'b0};
          end else begin
            mosi  <= 1'b0;
            tx_sh <= bus.tx_data;
          end
        end
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (sclk_edge) begin
          sclk     <= ~sclk;
          edge_cnt <= edge_num;
        end
        if (sample_edge) rx_sh <= {rx_sh[DATA_W-2:0], sample_bit};
        if (drive_edge) begin
          mosi  <= tx_sh[DATA_W-1];
          tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
        end
        if (state == TRAIL && tick) begin
          cs_n        <= '1;
          mosi        <= 1'b0;
          bus.rx_data <= rx_sh;
          bus.done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master -- self-checking bench for spi_master.
// Two instances: A (defaults: 8 bits, divide 2, one select) and
// B (16 bits, divide 1, four selects). Expected pin waveforms come from the
// edge-timing arithmetic of a transfer (edge k at T+1+k*CLK_DIV), and the
// slave drives miso from the same arithmetic.
module tb_spi_master;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  spi_master_if #(.DATA_W(8),  .CS_W(1)) bus_a ();
  spi_master_if #(.DATA_W(16), .CS_W(2)) bus_b ();
  logic       sclk_a, mosi_a, miso_a;
  logic [0:0] cs_n_a;
  logic       sclk_b, mosi_b, miso_b;
  logic [3:0] cs_n_b;

  spi_master #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a));

  spi_master #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic st, input logic [31:0] tx,
                        input logic [1:0] md, input int cs, input logic lb);
    if (sel == 0) begin
      bus_a.start = st; bus_a.tx_data = tx[7:0]; bus_a.mode = md; bus_a.cs_sel = cs[0];
`ifdef SPI_MASTER_LOOPBACK_EN
      bus_a.loopback = lb;
`endif
    end else begin
      bus_b.start = st; bus_b.tx_data = tx[15:0]; bus_b.mode = md; bus_b.cs_sel = cs[1:0];
`ifdef SPI_MASTER_LOOPBACK_EN
      bus_b.loopback = lb;
`endif
    end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel == 0) bus_a.start = st; else bus_b.start = st;
  endtask

  task automatic set_miso(input int sel, input logic v);
    if (sel == 0) miso_a = v; else miso_b = v;
  endtask

  // Unused select bits of instance A read as inactive (1).
  task automatic read_out(input int sel, output logic sc, output logic mo, output logic dn,
                          output logic rdy, output logic [3:0] csn, output logic [31:0] rx);
    if (sel == 0) begin
      sc = sclk_a; mo = mosi_a; dn = bus_a.done; rdy = bus_a.ready;
      csn = {3'b111, cs_n_a}; rx = {24'd0, bus_a.rx_data};
    end else begin
      sc = sclk_b; mo = mosi_b; dn = bus_b.done; rdy = bus_b.ready;
      csn = cs_n_b; rx = {16'd0, bus_b.rx_data};
    end
  endtask

  // Runs one transfer starting in the current cycle T and ending in the done
  // cycle T+ndone. Leaving start high (hold) makes the next call back-to-back.
  task automatic run_xfer(input int sel, input logic [31:0] tx_in, input logic [31:0] slv_in,
                          input logic [1:0] md, input int cs, input bit hold, input bit lb);
    int W   = (sel == 0) ? 8 : 16;
    int D   = (sel == 0) ? 2 : 1;
    int ncs = (sel == 0) ? 1 : 4;
    int ndone, e, j;
    logic [31:0] tx, slv, exp_rx, rx;
    logic [3:0]  exp_cs, csn;
    logic        sc, mo, dn, rdy, exp_mo;
    logic [7:0]  obs, exp;
    tx     = tx_in  & ((32'd1 << W) - 1);
    slv    = slv_in & ((32'd1 << W) - 1);
    ndone  = 1 + (2 * W + 1) * D;
    exp_cs = 4'hF;
    if (cs < ncs) exp_cs[cs] = 1'b0;
    exp_rx = slv;
`ifdef SPI_MASTER_LOOPBACK_EN
    if (lb) exp_rx = tx;
`endif
    read_out(sel, sc, mo, dn, rdy, csn, rx);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_start sel=%0d got %b want 1", sel, rdy);
    end
    set_in(sel, 1'b1, tx, md, cs, lb);
    for (int n = 1; n <= ndone; n++) begin
      tick();
      // Scramble the request fields while busy: the transfer must not notice.
      if (n == 1) set_in(sel, hold, $urandom, 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      else if (!hold && n == 3) set_start(sel, 1'b1);
      else if (!hold && n == 4) set_start(sel, 1'b0);
      e = (n - 1) / D;
      if (e > 2 * W) e = 2 * W;
      j = (md[0] == 1'b0) ? e / 2 : ((e == 0) ? 0 : (e - 1) / 2);
      if (j > W - 1) j = W - 1;
      set_miso(sel, (n == ndone) ? 1'b0 : slv[W-1-j]);
      read_out(sel, sc, mo, dn, rdy, csn, rx);
      if (n < ndone) begin
        exp_mo = (md[0] && e == 0) ? 1'b0 : tx[W-1-j];
        exp = {exp_cs, md[1] ^ e[0], exp_mo, 1'b0, 1'b0};
      end else begin
        exp = {4'hF, md[1], 1'b0, 1'b1, 1'b1};
      end
      obs = {csn, sc, mo, dn, rdy};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL xfer_pins sel=%0d mode=%0d n=%0d {cs_n,sclk,mosi,done,ready} got %b want %b",
                 sel, md, n, obs, exp);
      end
    end
    checks++;
    if (rx !== exp_rx) begin
      errors++;
      $display("FAIL rx_data sel=%0d mode=%0d got %h want %h", sel, md, rx, exp_rx);
    end
  endtask

  task automatic test_reset();
    logic sc, mo, dn, rdy;
    logic [3:0] csn;
    logic [31:0] rx;
    set_in(0, 1'b0, 0, 2'd0, 0, 1'b0);
    set_in(1, 1'b0, 0, 2'd0, 0, 1'b0);
    miso_a = 1'b0; miso_b = 1'b0;
    reset = 1'b1;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      read_out(s, sc, mo, dn, rdy, csn, rx);
      checks++;
      if ({csn, sc, mo, dn, rdy} !== 8'b1111_0001) begin
        errors++;
        $display("FAIL reset_pins sel=%0d got %b want 11110001", s, {csn, sc, mo, dn, rdy});
      end
      checks++;
      if (rx !== 32'd0) begin
        errors++;
        $display("FAIL reset_rx sel=%0d got %h want 0", s, rx);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mode0();
    run_xfer(0, 32'hA5, 32'h3C, 2'd0, 0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      set_in(0, 1'b0, 32'h81, 2'(m), 0, 1'b0);
      tick(); tick();
      checks++;
      if (sclk_a !== 1'(m >> 1)) begin
        errors++;
        $display("FAIL idle_sclk mode=%0d got %b want %b", m, sclk_a, 1'(m >> 1));
      end
      run_xfer(0, 32'h81, 32'h7E, 2'(m), 0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_wide();
    run_xfer(1, 32'hBEEF, 32'h1234, 2'd0, 2, 1'b0, 1'b0);
    tick();
    run_xfer(1, 32'hBEEF, 32'h1234, 2'd3, 2, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_cs_out_of_range();
    run_xfer(0, $urandom, 32'h96, 2'($urandom), 1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 3; k++)
        run_xfer(s, $urandom, $urandom, 2'($urandom), (s == 0) ? 0 : int'($urandom_range(0, 3)),
                 k < 2, 1'b0);
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int s = i % 2;
      run_xfer(s, $urandom, $urandom, 2'($urandom),
               (s == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3)), 1'b0, 1'b0);
      for (int g = 0; g <= int'($urandom_range(0, 3)); g++) tick();
    end
  endtask

  task automatic test_reset_mid();
    logic sc, mo, dn, rdy;
    logic [3:0] csn;
    logic [31:0] rx;
    set_in(0, 1'b1, 32'hC3, 2'd0, 0, 1'b0);
    miso_a = 1'b1;
    tick();
    set_start(0, 1'b0);
    for (int n = 2; n <= 11; n++) tick();
    // Cycle T+11: edge 5 (a rising edge in mode 0) has just been produced.
    checks++;
    if ({cs_n_a, sclk_a} !== 2'b01) begin
      errors++;
      $display("FAIL mid_xfer sel=0 {cs_n,sclk} got %b want 01", {cs_n_a, sclk_a});
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_out(0, sc, mo, dn, rdy, csn, rx);
    checks++;
    if ({csn, sc, mo, dn, rdy} !== 8'b1111_0001) begin
      errors++;
      $display("FAIL reset_mid_pins got %b want 11110001", {csn, sc, mo, dn, rdy});
    end
    checks++;
    if (rx !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_rx got %h want 0", rx);
    end
    tick();
    run_xfer(0, $urandom, $urandom, 2'($urandom), 0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_loopback();
    run_xfer(0, 32'h5A, 32'h00, 2'd0, 0, 1'b0, 1'b1);
    tick();
    run_xfer(1, 32'hA55A, 32'h0000, 2'd1, 1, 1'b0, 1'b1);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_mode0();
    test_modes();
    test_wide();
    test_cs_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Parametrised SPI master; next generation of the team's simplified 8-bit SPI block.
- Adds: configurable word width, programmable SCLK divider, all four SPI modes selectable per transfer, multiple chip selects, start/ready/done handshake.
- Sits between a peripheral-bus register front end (driving tx_data/start, reading rx_data/done) and the external SPI pins.

Parameters:
- DATA_W, 8: bits per transfer; min 2.
- CLK_DIV, 2: clk cycles per SCLK half-period; min 1.
- NUM_CS, 1: number of active-low chip selects; min 1.
- CS_W, $clog2(NUM_CS) or 1 if NUM_CS=1: width of cs_sel.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  transfer request; accepted only when ready=1.
- tx_data  in  DATA_W  word to shift out; latched on acceptance.
- mode  in  2  {CPOL,CPHA}; latched on acceptance; also sets idle SCLK level.
- cs_sel  in  CS_W  chip select index; latched on acceptance.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse at transfer end.
- rx_data  out  DATA_W  received word; updated at done, held until next done.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs_n  out  NUM_CS  chip selects, active low.

Behaviour:
- Reset (synchronous; takes effect on the next edge, including mid-transfer):
  - Outputs: cs_n all 1, sclk=0, mosi=0, ready=1, done=0, rx_data=0.
  - State returns to IDLE; shift registers and counters cleared.
- FSM states: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - ready=1; sclk follows mode[1], registered.
  - start=1 in cycle T: latch tx_data, mode, cs_sel; go to LEAD.
  - start while ready=0 is ignored; no queueing.
- LEAD:
  - From T+1: cs_n[cs_sel]=0, ready=0.
  - If CPHA=0, mosi = tx MSB from T+1.
  - Lasts CLK_DIV cycles.
- SHIFT:
  - 2*DATA_W SCLK edges; edge k (k=1..2*DATA_W) toggles sclk at cycle T+1+k*CLK_DIV.
  - Odd edges are leading, even edges trailing.
  - CPHA=0: sample miso on leading edges; drive next mosi bit on trailing edges, except the final trailing edge.
  - CPHA=1: drive mosi on leading edges (first bit on edge 1); sample on trailing edges.
  - MSB first for both tx and rx.
  - After the last edge, sclk rests at CPOL.
- TRAIL:
  - CS hold of CLK_DIV cycles after the last edge.
  - Then, at cycle T+1+(2*DATA_W+1)*CLK_DIV: cs_n all 1, mosi=0, rx_data updated, done=1, ready=1, state=IDLE.
- Back-to-back transfers: start in the done cycle is accepted. cs_n is low again at the following cycle, so the minimum cs_n high time is 1 clk.
- cs_sel >= NUM_CS: transfer runs normally with all cs_n held high; rx_data still updated.
- Sampling: the miso sample is taken on the clk edge that produces the SCLK sampling edge. No extra synchroniser (external timing responsibility).
- Divider counter width is $clog2(CLK_DIV+1); the counter wraps to 0 on each SCLK edge.
- mode changes while busy have no effect on the current transfer.

Optional Feature:
- SPI_MASTER_LOOPBACK_EN defined:
  - Adds input port loopback (1 bit), latched with the other transfer fields on acceptance.
  - When the latched value is 1, the sampled bit is the internal mosi instead of the miso pin, so rx_data == tx_data at done.
  - Pins behave identically otherwise.
- Not defined: no loopback port; miso is always sampled.

Test Plan:
- Defaults, mode 0, tx_data=0xA5, slave model returns 0x3C, start at T:
  - cs_n[0] falls at T+1.
  - sclk rises at T+3, T+7, ..., T+31.
  - mosi bit sequence 1,0,1,0,0,1,0,1.
  - done and rx_data=0x3C at T+35; cs_n=1 at T+35.
- Modes 1, 2, 3 with tx_data=0x81, slave returns 0x7E:
  - Idle sclk = CPOL.
  - Sample/drive on the correct edges; rx_data=0x7E each time.
- DATA_W=16, CLK_DIV=1, NUM_CS=4, cs_sel=2, tx_data=0xBEEF:
  - Only cs_n[2] low.
  - done at T+34.
  - 32 sclk edges; rx matches slave value 0x1234.
- start held high continuously for 3 transfers:
  - Each new transfer accepted in the prior done cycle.
  - cs_n high exactly 1 cycle between transfers.
  - start pulses during busy are ignored.
- reset asserted at edge 5 of a transfer:
  - Next cycle: cs_n all 1, sclk=0, mosi=0, ready=1, done=0, rx_data=0.
  - A new transfer then completes correctly.
- With SPI_MASTER_LOOPBACK_EN, loopback=1, miso tied 0, tx_data=0x5A:
  - rx_data=0x5A.
  - Repeat without the macro: rx_data=0x00.
